// File: rtl/led_pattern_sequencer.sv
// LED chaser: CH pattern registers step on a prescaled tick and drive a mirrored LED bar.
// Optional feature macro LED_PWM_EN adds a duty input and PWM dimming of the bar.
module led_pattern_sequencer #(
    parameter int CH    = 4,
    parameter int PLEN  = 5,
    parameter int DIV_W = 8,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [CHW-1:0]   load_ch,
    input  logic [PLEN-1:0]  load_pat,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [2*CH-1:0]  leds,
    output logic             step_tick
);

    localparam int POSW = $clog2(PLEN);
    localparam logic [POSW-1:0] POS_LAST = POSW'(PLEN - 1);

    typedef enum logic [1:0] {
        MODE_RR     = 2'b00,
        MODE_RL     = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic [POSW-1:0]          pos_q, pos_d, pos_eff;
    dir_e                     dir_q, dir_d, dir_eff;
    mode_e                    mode_prev_q;
    logic [CH-1:0][PLEN-1:0]  pat_q, pat_d;
    logic [2*CH-1:0]          leds_q, leds_d;
    logic                     step_tick_q;
    logic                     tick;
    logic                     entering;
    logic                     do_shift;
    logic                     shift_left;

    function automatic logic [PLEN-1:0] seed(input int k);
        return (PLEN'(1) << (PLEN - 1)) | (PLEN'(1) << (k % (PLEN - 1)));
    endfunction

    // Bounce position/direction restart whenever mode 10 is freshly selected.
    always_comb begin
        tick       = en && (cnt_q >= div);
        entering   = (mode == MODE_BOUNCE) && (mode_prev_q != MODE_BOUNCE);
        pos_eff    = entering ? '0 : pos_q;
        dir_eff    = entering ? DIR_RIGHT : dir_q;
        pos_d      = pos_eff;
        dir_d      = dir_eff;
        do_shift   = 1'b0;
        shift_left = 1'b0;
        cnt_d      = cnt_q;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end

        if (tick) begin
            case (mode_e'(mode))
                MODE_RR: do_shift = 1'b1;
                MODE_RL: begin
                    do_shift   = 1'b1;
                    shift_left = 1'b1;
                end
                MODE_BOUNCE: begin
                    do_shift = 1'b1;
                    if (dir_eff == DIR_RIGHT) begin
                        if (pos_eff == POS_LAST) begin
                            dir_d      = DIR_LEFT;
                            shift_left = 1'b1;
                            pos_d      = pos_eff - POSW'(1);
                        end else begin
                            pos_d = pos_eff + POSW'(1);
                        end
                    end else begin
                        if (pos_eff == '0) begin
                            dir_d = DIR_RIGHT;
                            pos_d = pos_eff + POSW'(1);
                        end else begin
                            shift_left = 1'b1;
                            pos_d      = pos_eff - POSW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // A load wins over the step for its own channel; out-of-range channels never match.
        for (int k = 0; k < CH; k++) begin
            pat_d[k] = pat_q[k];
            if (do_shift) begin
                pat_d[k] = shift_left ? {pat_q[k][PLEN-2:0], pat_q[k][PLEN-1]}
                                      : {pat_q[k][0], pat_q[k][PLEN-1:1]};
            end
            if (load && (load_ch == CHW'(k))) begin
                pat_d[k] = load_pat;
            end
        end

        leds_d = '0;
        for (int k = 0; k < CH; k++) begin
            leds_d[2*CH-1-k] = pat_q[k][0];
            leds_d[k]        = pat_q[k][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_RIGHT;
            mode_prev_q <= MODE_RR;
            leds_q      <= '0;
            step_tick_q <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                pat_q[k] <= seed(k);
            end
        end else begin
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            mode_prev_q <= mode_e'(mode);
            leds_q      <= leds_d;
            step_tick_q <= tick;
            pat_q       <= pat_d;
        end
    end

    assign step_tick = step_tick_q;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    assign leds = leds_q & {(2*CH){pwm_cnt_q < duty}};
`else
    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer (default build, CH=4, PLEN=5, DIV_W=8).
// Expected patterns and LED bars are hand-derived from the seed values 10001,10010,10100,11000.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] div;
    logic       load;
    logic [1:0] load_ch;
    logic [4:0] load_pat;
    logic [7:0] leds;
    logic       step_tick;
`ifdef LED_PWM_EN
    logic [3:0] duty = 4'd15;
`endif

    int total = 0;
    int bad   = 0;

    led_pattern_sequencer #(.CH(4), .PLEN(5), .DIV_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .div      (div),
        .load     (load),
        .load_ch  (load_ch),
        .load_pat (load_pat),
`ifdef LED_PWM_EN
        .duty     (duty),
`endif
        .leds     (leds),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        total++;
        if (leds !== 8'h00) begin bad++; $display("[TB] FAIL reset_leds got=%h want=00", leds); end
        total++;
        if (step_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got=%b want=0", step_tick); end
        stepClk(1);
        total++;
        if (dut.pat_q[0] !== 5'b10001) begin bad++; $display("[TB] FAIL reset_seed0 got=%b want=10001", dut.pat_q[0]); end
        rst_n = 1'b1;
        stepClk(3);
        // Assert reset between edges: outputs must clear without waiting for a clock.
        rst_n = 1'b0;
        #2;
        total++;
        if (leds !== 8'h00) begin bad++; $display("[TB] FAIL async_leds got=%h want=00", leds); end
        total++;
        if (step_tick !== 1'b0) begin bad++; $display("[TB] FAIL async_tick got=%b want=0", step_tick); end
        total++;
        if (dut.pat_q[3] !== 5'b11000) begin bad++; $display("[TB] FAIL async_seed3 got=%b want=11000", dut.pat_q[3]); end
        total++;
        if (dut.pat_q[1] !== 5'b10010) begin bad++; $display("[TB] FAIL async_seed1 got=%b want=10010", dut.pat_q[1]); end
        stepClk(1);
        total++;
        if (leds !== 8'h00) begin bad++; $display("[TB] FAIL held_reset_leds got=%h want=00", leds); end
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_right();
        logic [7:0] ledsExp [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF};
        logic [4:0] patExp  [5] = '{5'b11000, 5'b01100, 5'b00110, 5'b00011, 5'b10001};
        en = 1'b1; div = 8'd0; mode = 2'b00; load = 1'b0;
        doReset();
        for (int i = 0; i < 5; i++) begin
            stepClk(1);
            total++;
            if (leds !== ledsExp[i]) begin bad++; $display("[TB] FAIL rr_leds[%0d] got=%h want=%h", i, leds, ledsExp[i]); end
            total++;
            if (dut.pat_q[0] !== patExp[i]) begin bad++; $display("[TB] FAIL rr_pat0[%0d] got=%b want=%b", i, dut.pat_q[0], patExp[i]); end
            total++;
            if (step_tick !== 1'b1) begin bad++; $display("[TB] FAIL rr_tick[%0d] got=%b want=1", i, step_tick); end
        end
    endtask

    task automatic test_rotate_left();
        en = 1'b1; div = 8'd0; mode = 2'b01; load = 1'b0;
        doReset();
        stepClk(1);
        total++;
        if (dut.pat_q[0] !== 5'b00011) begin bad++; $display("[TB] FAIL rl_pat0 got=%b want=00011", dut.pat_q[0]); end
        total++;
        if (dut.pat_q[3] !== 5'b10001) begin bad++; $display("[TB] FAIL rl_pat3 got=%b want=10001", dut.pat_q[3]); end
        stepClk(1);
        total++;
        if (leds !== 8'hFF) begin bad++; $display("[TB] FAIL rl_leds got=%h want=ff", leds); end
        total++;
        if (dut.pat_q[0] !== 5'b00110) begin bad++; $display("[TB] FAIL rl_pat0b got=%b want=00110", dut.pat_q[0]); end
    endtask

    task automatic test_prescaler();
        en = 1'b1; div = 8'd3; mode = 2'b00; load = 1'b0;
        doReset();
        for (int e = 1; e <= 12; e++) begin
            stepClk(1);
            total++;
            if (step_tick !== ((e % 4) == 0)) begin
                bad++; $display("[TB] FAIL div3_tick[%0d] got=%b want=%b", e, step_tick, ((e % 4) == 0));
            end
        end
        total++;
        if (dut.pat_q[0] !== 5'b00110) begin bad++; $display("[TB] FAIL div3_pat0 got=%b want=00110", dut.pat_q[0]); end
        en = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            stepClk(1);
            total++;
            if (step_tick !== 1'b0) begin bad++; $display("[TB] FAIL freeze_tick[%0d] got=%b want=0", e, step_tick); end
            total++;
            if (leds !== 8'h18) begin bad++; $display("[TB] FAIL freeze_leds[%0d] got=%h want=18", e, leds); end
        end
        total++;
        if (dut.pat_q[0] !== 5'b00110) begin bad++; $display("[TB] FAIL freeze_pat0 got=%b want=00110", dut.pat_q[0]); end
        en = 1'b1;
        stepClk(3);
        total++;
        if (step_tick !== 1'b0) begin bad++; $display("[TB] FAIL resume_early got=%b want=0", step_tick); end
        stepClk(1);
        total++;
        if (step_tick !== 1'b1) begin bad++; $display("[TB] FAIL resume_tick got=%b want=1", step_tick); end
        div = 8'd7;
        stepClk(6);
        total++;
        if (step_tick !== 1'b0) begin bad++; $display("[TB] FAIL div7_quiet got=%b want=0", step_tick); end
        div = 8'd2;
        stepClk(1);
        total++;
        if (step_tick !== 1'b1) begin bad++; $display("[TB] FAIL div_shrink_tick got=%b want=1", step_tick); end
    endtask

    task automatic test_bounce();
        logic [4:0] walkExp  [10] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00100,
                                      5'b01000, 5'b10000, 5'b00001, 5'b10000, 5'b01000};
        logic [4:0] reentExp [5]  = '{5'b00010, 5'b00001, 5'b10000, 5'b01000, 5'b10000};
        en = 1'b0; div = 8'd0; mode = 2'b10; load = 1'b0;
        doReset();
        load = 1'b1; load_ch = 2'd0; load_pat = 5'b00001;
        stepClk(1);
        load = 1'b0;
        total++;
        if (dut.pat_q[0] !== 5'b00001) begin bad++; $display("[TB] FAIL frozen_load got=%b want=00001", dut.pat_q[0]); end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepClk(1);
            total++;
            if (dut.pat_q[0] !== walkExp[i]) begin bad++; $display("[TB] FAIL bounce_pat0[%0d] got=%b want=%b", i, dut.pat_q[0], walkExp[i]); end
            if (i == 0 || i == 8) begin
                total++;
                if (leds[0] !== 1'b1 || leds[7] !== 1'b1) begin bad++; $display("[TB] FAIL bounce_lit[%0d] got=%h want=ch0 pair lit", i, leds); end
            end
            if (i == 1) begin
                total++;
                if (leds[0] !== 1'b0) begin bad++; $display("[TB] FAIL bounce_dark got=%b want=0", leds[0]); end
            end
            if (i == 4) begin
                total++;
                if (dut.dir_q !== 1'b1) begin bad++; $display("[TB] FAIL bounce_dir got=%b want=1", dut.dir_q); end
            end
        end
        mode = 2'b00;
        stepClk(1);
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            stepClk(1);
            total++;
            if (dut.pat_q[0] !== reentExp[i]) begin bad++; $display("[TB] FAIL reenter_pat0[%0d] got=%b want=%b", i, dut.pat_q[0], reentExp[i]); end
        end
    endtask

    task automatic test_load();
        en = 1'b1; div = 8'd0; mode = 2'b00; load = 1'b0;
        doReset();
        load = 1'b1; load_ch = 2'd2; load_pat = 5'b11111;
        stepClk(1);
        load = 1'b0;
        total++;
        if (dut.pat_q[2] !== 5'b11111) begin bad++; $display("[TB] FAIL load_pat2 got=%b want=11111", dut.pat_q[2]); end
        total++;
        if (dut.pat_q[0] !== 5'b11000) begin bad++; $display("[TB] FAIL load_pat0 got=%b want=11000", dut.pat_q[0]); end
        total++;
        if (dut.pat_q[1] !== 5'b01001) begin bad++; $display("[TB] FAIL load_pat1 got=%b want=01001", dut.pat_q[1]); end
        total++;
        if (dut.pat_q[3] !== 5'b01100) begin bad++; $display("[TB] FAIL load_pat3 got=%b want=01100", dut.pat_q[3]); end
        total++;
        if (step_tick !== 1'b1) begin bad++; $display("[TB] FAIL load_tick got=%b want=1", step_tick); end
        stepClk(1);
        total++;
        if (leds !== 8'h66) begin bad++; $display("[TB] FAIL load_leds got=%h want=66", leds); end
    endtask

    task automatic test_hold();
        int pulses = 0;
        en = 1'b1; div = 8'd1; mode = 2'b11; load = 1'b0;
        doReset();
        for (int i = 0; i < 10; i++) begin
            stepClk(1);
            if (step_tick === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 5) begin bad++; $display("[TB] FAIL hold_pulses got=%0d want=5", pulses); end
        total++;
        if (dut.pat_q[0] !== 5'b10001) begin bad++; $display("[TB] FAIL hold_pat0 got=%b want=10001", dut.pat_q[0]); end
        total++;
        if (dut.pat_q[2] !== 5'b10100) begin bad++; $display("[TB] FAIL hold_pat2 got=%b want=10100", dut.pat_q[2]); end
        total++;
        if (leds !== 8'h81) begin bad++; $display("[TB] FAIL hold_leds got=%h want=81", leds); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; div = 8'd0;
        load = 1'b0; load_ch = 2'd0; load_pat = 5'd0;
        #2;
        test_reset();
        test_rotate_right();
        test_rotate_left();
        test_prescaler();
        test_bounce();
        test_load();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
